// File: rtl/dmem_arbiter.sv
// Shares the single-port Data_Memory between the CPU MEM stage (port 0) and a debug/init loader (port 1); DMEM_ARB_FIXED_PRIO_EN makes port 0 win every tie.
// Latency: request seen in C0, mem_en in C1, rvalid in C(MEM_LAT+1); one transaction per MEM_LAT+2 cycles.
// Backpressure: a waiting requester holds valid and fields until its rvalid; stall_o holds the CPU pipeline meanwhile.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic              req0_we_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              req0_rvalid_o,
    output logic [DATA_W-1:0] req0_rdata_o,
    input  logic              req1_valid_i,
    input  logic              req1_we_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              req1_rvalid_o,
    output logic [DATA_W-1:0] req1_rdata_o,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              any_req;
    logic              grant1;
    logic              in_access;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_grant_q;
`endif

    assign any_req = req0_valid_i | req1_valid_i;

    always_comb begin
        grant1 = 1'b0;
        if (req1_valid_i && !req0_valid_i) begin
            grant1 = 1'b1;
        end
`ifndef DMEM_ARB_FIXED_PRIO_EN
        // Tie goes to whichever port was not granted last.
        else if (req1_valid_i && req0_valid_i) begin
            grant1 = ~last_grant_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            owner_q <= grant1;
            we_q    <= grant1 ? req1_we_i    : req0_we_i;
            addr_q  <= grant1 ? req1_addr_i  : req0_addr_i;
            wdata_q <= grant1 ? req1_wdata_i : req0_wdata_i;
            cnt_q   <= CNT_INIT;
        end else if (state_q == ACCESS) begin
            if (cnt_q == '0) begin
                // Writes return zero so a store never exposes stale bus data.
                if (owner_q) begin
                    rdata1_q <= we_q ? '0 : mem_rdata_i;
                end else begin
                    rdata0_q <= we_q ? '0 : mem_rdata_i;
                end
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_grant_q <= grant1;
        end
    end
`endif

    assign in_access     = (state_q == ACCESS);
    assign mem_en_o      = in_access && (cnt_q == CNT_INIT);
    assign mem_we_o      = in_access && we_q;
    assign mem_addr_o    = in_access ? addr_q : '0;
    assign mem_wdata_o   = in_access ? wdata_q : '0;
    assign req0_rvalid_o = (state_q == RESP) && !owner_q;
    assign req1_rvalid_o = (state_q == RESP) && owner_q;
    assign req0_rdata_o  = rdata0_q;
    assign req1_rdata_o  = rdata1_q;
    // Gated by reset so every output reads zero while reset is held.
    assign stall_o       = rst_i && req0_valid_i && !req0_rvalid_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset-abort and priority sequences, then random traffic
// checked against a transaction-level model of grants, completion times and memory contents.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int MEM_LAT = 2;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_we_i, req1_valid_i, req1_we_i;
    logic [31:0] req0_addr_i, req0_wdata_i, req1_addr_i, req1_wdata_i;
    logic        req0_rvalid_o, req1_rvalid_o, stall_o, mem_en_o, mem_we_o;
    logic [31:0] req0_rdata_o, req1_rdata_o, mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_we_i(req0_we_i), .req0_addr_i(req0_addr_i),
        .req0_wdata_i(req0_wdata_i), .req0_rvalid_o(req0_rvalid_o), .req0_rdata_o(req0_rdata_o),
        .req1_valid_i(req1_valid_i), .req1_we_i(req1_we_i), .req1_addr_i(req1_addr_i),
        .req1_wdata_i(req1_wdata_i), .req1_rvalid_o(req1_rvalid_o), .req1_rdata_o(req1_rdata_o),
        .stall_o(stall_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input int idx);
        return (idx == 2) ? 32'd10 : 32'h1000 + 32'(idx);
    endfunction

    // Data_Memory: write on the enable edge; read data appears only in the last ACCESS cycle.
    bit [31:0]  dmem [256];
    bit [255:0] dmem_wr;
    always @(posedge clk_i) begin
        mem_rdata_i <= 32'hDEAD_BEEF;
        if (mem_en_o && mem_we_o) begin
            dmem[mem_addr_o[9:2]]    <= mem_wdata_o;
            dmem_wr[mem_addr_o[9:2]] <= 1'b1;
        end else if (mem_en_o) begin
            mem_rdata_i <= dmem_wr[mem_addr_o[9:2]] ? dmem[mem_addr_o[9:2]]
                                                    : init_word(int'(mem_addr_o[9:2]));
        end
    end

    typedef struct {
        logic        rst_n;
        logic        v0, we0;
        logic [31:0] a0, d0;
        logic        v1, we1;
        logic [31:0] a1, d1;
        logic        rv0, rv1, stall, en, we;
        logic [31:0] addr, wdata, rd0, rd1;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] dut_pack();
        return {27'd0, req0_rvalid_o, req1_rvalid_o, stall_o, mem_en_o, mem_we_o,
                mem_addr_o, mem_wdata_o, req0_rdata_o, req1_rdata_o};
    endfunction

    function automatic logic [159:0] exp_pack(input vec_t v);
        return {27'd0, v.rv0, v.rv1, v.stall, v.en, v.we, v.addr, v.wdata, v.rd0, v.rd1};
    endfunction

    task automatic drive(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
        req0_valid_i = v0; req0_we_i = we0; req0_addr_i = a0; req0_wdata_i = d0;
        req1_valid_i = v1; req1_we_i = we1; req1_addr_i = a1; req1_wdata_i = d1;
    endtask

    // Random-phase model state
    bit          act [2];
    bit          granted [2];
    logic        we_r [2];
    logic [31:0] a_r [2], d_r [2], exp_rd [2];
    int          done_at [2];
    bit [31:0]   ref_mem [256];
    bit [255:0]  ref_wr;

    initial begin
        rst_i = 1'b1;
        drive(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0);
        #2 rst_i = 1'b0;

        // rst, v0 we0 a0 d0, v1 we1 a1 d1, rv0 rv1 stall en we, addr wdata rd0 rd1
        vq.push_back('{L, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,L,L,L, 32'h0,32'h0,32'h0,32'h0});
        vq.push_back('{L, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,L,L,L, 32'h0,32'h0,32'h0,32'h0});
        vq.push_back('{H, H,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h0,32'h0,32'h0,32'h0});
        vq.push_back('{H, H,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,H,H,L, 32'h0,32'h0,32'h0,32'h0});
        vq.push_back('{H, H,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h0,32'h0,32'h0,32'h0});
        vq.push_back('{H, H,L,32'h00,32'h0, H,L,32'h04,32'h0, H,L,L,L,L, 32'h0,32'h0,32'h1000,32'h0});
`ifndef DMEM_ARB_FIXED_PRIO_EN
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h0,32'h0,32'h1000,32'h0});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,H,L, 32'h04,32'h0,32'h1000,32'h0});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h04,32'h0,32'h1000,32'h0});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,H,H,L,L, 32'h0,32'h0,32'h1000,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h0,32'h0,32'h1000,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,H,L, 32'h08,32'h0,32'h1000,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h08,32'h0,32'h1000,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, H,L,L,L,L, 32'h0,32'h0,32'd10,32'h1001});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,L,L,L, 32'h0,32'h0,32'd10,32'h1001});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,L,H,L, 32'h04,32'h0,32'd10,32'h1001});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,L,L,L, 32'h04,32'h0,32'd10,32'h1001});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,H,L,L,L, 32'h0,32'h0,32'd10,32'h1001});
`else
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h0,32'h0,32'h1000,32'h0});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,H,L, 32'h08,32'h0,32'h1000,32'h0});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, L,L,H,L,L, 32'h08,32'h0,32'h1000,32'h0});
        vq.push_back('{H, H,L,32'h08,32'h0, H,L,32'h04,32'h0, H,L,L,L,L, 32'h0,32'h0,32'd10,32'h0});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,L,L,L, 32'h0,32'h0,32'd10,32'h0});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,L,H,L, 32'h04,32'h0,32'd10,32'h0});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,L,L,L,L, 32'h04,32'h0,32'd10,32'h0});
        vq.push_back('{H, L,L,32'h00,32'h0, H,L,32'h04,32'h0, L,H,L,L,L, 32'h0,32'h0,32'd10,32'h1001});
`endif
        vq.push_back('{H, L,L,32'h00,32'h0, L,L,32'h00,32'h0, L,L,L,L,L, 32'h0,32'h0,32'd10,32'h1001});
        // Store 29 to 0x10, then load 0x08 and read 0x10 back-to-back.
        vq.push_back('{H, H,H,32'h10,32'd29, L,L,32'h0,32'h0, L,L,H,L,L, 32'h0,32'h0,32'd10,32'h1001});
        vq.push_back('{H, H,H,32'h10,32'd29, L,L,32'h0,32'h0, L,L,H,H,H, 32'h10,32'd29,32'd10,32'h1001});
        vq.push_back('{H, H,H,32'h10,32'd29, L,L,32'h0,32'h0, L,L,H,L,H, 32'h10,32'd29,32'd10,32'h1001});
        vq.push_back('{H, H,H,32'h10,32'd29, L,L,32'h0,32'h0, H,L,L,L,L, 32'h0,32'h0,32'h0,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, L,L,32'h0,32'h0, L,L,H,L,L, 32'h0,32'h0,32'h0,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, L,L,32'h0,32'h0, L,L,H,H,L, 32'h08,32'h0,32'h0,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, L,L,32'h0,32'h0, L,L,H,L,L, 32'h08,32'h0,32'h0,32'h1001});
        vq.push_back('{H, H,L,32'h08,32'h0, L,L,32'h0,32'h0, H,L,L,L,L, 32'h0,32'h0,32'd10,32'h1001});
        vq.push_back('{H, H,L,32'h10,32'h0, L,L,32'h0,32'h0, L,L,H,L,L, 32'h0,32'h0,32'd10,32'h1001});
        vq.push_back('{H, H,L,32'h10,32'h0, L,L,32'h0,32'h0, L,L,H,H,L, 32'h10,32'h0,32'd10,32'h1001});
        vq.push_back('{H, H,L,32'h10,32'h0, L,L,32'h0,32'h0, L,L,H,L,L, 32'h10,32'h0,32'd10,32'h1001});
        vq.push_back('{H, H,L,32'h10,32'h0, L,L,32'h0,32'h0, H,L,L,L,L, 32'h0,32'h0,32'd29,32'h1001});
        vq.push_back('{H, L,L,32'h00,32'h0, L,L,32'h0,32'h0, L,L,L,L,L, 32'h0,32'h0,32'd29,32'h1001});

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk_i); #1;
            rst_i = vq[i].rst_n;
            drive(vq[i].v0, vq[i].we0, vq[i].a0, vq[i].d0, vq[i].v1, vq[i].we1, vq[i].a1, vq[i].d1);
            @(negedge clk_i);
            check($sformatf("vec%0d", i), dut_pack(), exp_pack(vq[i]));
        end

`ifdef DMEM_ARB_FIXED_PRIO_EN
        // Port 0 re-requests three times; port 1 only wins once port 0 drops.
        for (int k = 0; k < 16; k++) begin
            @(posedge clk_i); #1;
            drive((k < 12) ? H : L, L, 32'h08, 32'h0, H, L, 32'h04, 32'h0);
            @(negedge clk_i);
            check($sformatf("starve%0d", k), 160'({req0_rvalid_o, req1_rvalid_o}),
                  160'({(k < 12) && (k % 4 == 3), k == 15}));
        end
        @(posedge clk_i); #1;
        drive(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0);
`endif

        // Reset in the second ACCESS cycle aborts the load; the held request restarts cleanly.
        @(posedge clk_i); #1;
        drive(H, L, 32'h08, 32'h0, L, L, 32'h0, 32'h0);
        @(negedge clk_i);
        check("abort_c0", 160'({req0_rvalid_o, stall_o, mem_en_o}), 160'(3'b010));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("abort_c1", 160'({mem_en_o, mem_addr_o}), 160'({1'b1, 32'h08}));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1 check("abort_now", dut_pack(), 160'd0);
        @(negedge clk_i);
        check("abort_hold", dut_pack(), 160'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("restart_c0", 160'({req0_rvalid_o, stall_o, mem_en_o, mem_addr_o}), 160'({3'b010, 32'h0}));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("restart_c1", 160'({req0_rvalid_o, stall_o, mem_en_o, mem_addr_o}), 160'({3'b011, 32'h08}));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("restart_c2", 160'({req0_rvalid_o, stall_o, mem_en_o, mem_addr_o}), 160'({3'b010, 32'h08}));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("restart_c3", 160'({req0_rvalid_o, stall_o, req0_rdata_o}), 160'({2'b10, 32'd10}));

        // Random traffic against the transaction model, from a fresh reset.
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        begin
            int   free_at, en_at, g;
            bit   last;
            bit   pend [2];
            bit   exp_rv [2];
            logic en_we;
            logic [31:0] en_addr;
            free_at = 0; en_at = -1; last = 1'b1; en_we = 1'b0; en_addr = 32'h0;
            for (int p = 0; p < 2; p++) begin
                act[p] = 1'b0; granted[p] = 1'b0; done_at[p] = -1;
                we_r[p] = 1'b0; a_r[p] = 32'h0; d_r[p] = 32'h0; exp_rd[p] = 32'h0;
            end
            for (int n = 0; n < 1500; n++) begin
                @(posedge clk_i); #1;
                for (int p = 0; p < 2; p++) begin
                    if (!act[p] && ($urandom_range(0, 3) < ((p == 0) ? 3 : 2))) begin
                        act[p]  = 1'b1;
                        we_r[p] = 1'($urandom_range(0, 1));
                        a_r[p]  = 32'h40 + 32'($urandom_range(0, 15)) * 32'd4;
                        d_r[p]  = $urandom();
                    end
                end
                drive(act[0], we_r[0], a_r[0], d_r[0], act[1], we_r[1], a_r[1], d_r[1]);
                @(negedge clk_i);
                for (int p = 0; p < 2; p++) exp_rv[p] = (n == done_at[p]);
                check("rnd_ctl",
                      160'({req0_rvalid_o, req1_rvalid_o, stall_o, mem_en_o, mem_en_o & mem_we_o,
                            mem_en_o ? mem_addr_o : 32'h0}),
                      160'({exp_rv[0], exp_rv[1], act[0] & ~exp_rv[0], n == en_at,
                            (n == en_at) & en_we, (n == en_at) ? en_addr : 32'h0}));
                for (int p = 0; p < 2; p++) begin
                    if (exp_rv[p]) begin
                        check($sformatf("rnd_rdata%0d", p),
                              160'((p == 1) ? req1_rdata_o : req0_rdata_o), 160'(exp_rd[p]));
                        act[p] = 1'b0;
                        granted[p] = 1'b0;
                    end
                end
                for (int p = 0; p < 2; p++) pend[p] = act[p] && !granted[p];
                if (n >= free_at && (pend[0] || pend[1])) begin
                    if (pend[0] && pend[1]) g = (FIXED || last) ? 0 : 1;
                    else g = pend[1] ? 1 : 0;
                    last       = (g == 1);
                    granted[g] = 1'b1;
                    done_at[g] = n + MEM_LAT + 1;
                    free_at    = n + MEM_LAT + 2;
                    en_at      = n + 1;
                    en_addr    = a_r[g];
                    en_we      = we_r[g];
                    if (we_r[g]) begin
                        exp_rd[g] = 32'h0;
                        ref_mem[a_r[g][9:2]] = d_r[g];
                        ref_wr[a_r[g][9:2]]  = 1'b1;
                    end else begin
                        exp_rd[g] = ref_wr[a_r[g][9:2]] ? ref_mem[a_r[g][9:2]]
                                                        : init_word(int'(a_r[g][9:2]));
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port Data_Memory between two requesters.
- Port 0 is the CPU MEM stage (loads/stores). Port 1 is a debug/init loader that preloads or inspects memory while the CPU runs.
- Sequences each access over a fixed memory latency and generates the CPU pipeline stall.
- Sits between the MEM stage, the debug port and Data_Memory.

Parameters:
ADDR_W, 32, byte-address width on both ports and on the memory side
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles (>=1); read data is valid in the last ACCESS cycle

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req0_valid_i  in  1  CPU request; held high until req0_rvalid_o
req0_we_i  in  1  1 = store, 0 = load
req0_addr_i  in  ADDR_W  CPU address
req0_wdata_i  in  DATA_W  CPU store data
req0_rvalid_o  out  1  one-cycle completion pulse for port 0
req0_rdata_o  out  DATA_W  load data, valid with rvalid
req1_valid_i  in  1  debug request; same protocol as port 0
req1_we_i  in  1  debug write enable
req1_addr_i  in  ADDR_W  debug address
req1_wdata_i  in  DATA_W  debug write data
req1_rvalid_o  out  1  completion pulse for port 1
req1_rdata_o  out  DATA_W  debug read data
stall_o  out  1  CPU pipeline stall
mem_en_o  out  1  memory enable, first ACCESS cycle only
mem_we_o  out  1  memory write enable, qualifies mem_en_o
mem_addr_o  out  ADDR_W  latched address, held through ACCESS
mem_wdata_o  out  DATA_W  latched write data
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (rst_i=0, asynchronous, any state): state=IDLE, cnt=0, owner=0, last_grant=1 (port 0 wins the first tie), rdata regs=0. All outputs 0.
- Protocol: a requester holds valid and its fields stable until it sees its rvalid. The rvalid cycle completes the transaction. The requester may present a new request in the very next cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any valid is high, at the clock edge:
  - pick the winner and latch we/addr/wdata and owner;
  - set cnt=MEM_LAT-1;
  - go to ACCESS.
  - Otherwise stay in IDLE.
- Round robin: on a tie, grant the port not equal to last_grant. last_grant updates on each grant. A lone request is granted immediately.
- ACCESS:
  - mem_en_o=1 in the first ACCESS cycle only.
  - mem_we_o, mem_addr_o and mem_wdata_o are driven from the latched values for the whole state.
  - cnt decrements each cycle.
  - When cnt==0, capture mem_rdata_i into the owner's rdata reg (captures 0 for writes) and go to RESP.
- RESP: the owner's rvalid=1 for exactly one cycle, then go to IDLE. A new grant is never made in RESP.
- Latency: request first seen in cycle C0 → mem_en in C1 → rvalid in C(MEM_LAT+1). Occupancy is MEM_LAT+2 cycles per transaction. Back-to-back throughput is 1 per MEM_LAT+2 cycles.
- rdata_o holds its value after rvalid until the next completion on that port.
- stall_o = req0_valid_i & ~req0_rvalid_o. It is combinational and is high while the CPU request is waiting or in flight.
- Requests arriving during ACCESS/RESP wait. The losing port keeps valid high and is granted from the next IDLE.
- A change of valid/fields during ACCESS does not affect the latched transaction (protocol violation; no check required).
- Reset mid-ACCESS aborts the transaction: mem_en/mem_we drop immediately and no rvalid is issued.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a tie and last_grant is unused. Port 1 can starve while the CPU issues back-to-back memory instructions.
- Undefined (default): round robin as above.

Test Plan:
- Reset: hold rst_i=0 during traffic with both valids high → all outputs 0. After release with a tie, port 0 is granted first.
- Single CPU load, MEM_LAT=2, addr 0x08, memory returns 10:
  - mem_en_o=1 and mem_we_o=0 in C1 only, mem_addr_o=0x08 in C1–C2;
  - req0_rvalid_o=1 in C3 with req0_rdata_o=10;
  - stall_o=1 in C0–C2 and 0 in C3.
- CPU store addr 0x10, wdata 29 → mem_en_o=mem_we_o=1 in C1, mem_wdata_o=29, req0_rvalid_o in C3, req0_rdata_o=0.
- Simultaneous loads, port 0 addr 0x00 and port 1 addr 0x04, both held:
  - port 0 completes C3, port 1 completes C7;
  - with both re-requesting, the third grant goes to port 0.
- Same as the previous scenario with DMEM_ARB_FIXED_PRIO_EN and port 0 re-requesting continuously → port 1 is never granted. Port 1 is granted in the first IDLE cycle where req0_valid_i=0.
- Reset asserted in the second ACCESS cycle → no rvalid, mem_en_o=0 immediately, and the next request restarts cleanly with the correct C0→C3 timing.
